core_bus_arbiter: RTL and testbench
===================================

# core_bus_arbiter

Merges the core's two request channels, instruction fetch and data memory, onto the single request port of the MMU. Each channel issues one-cycle request pulses and waits for a one-cycle response pulse. The arbiter buffers one request per channel, serialises them with fixed data-over-fetch priority, tags the downstream request with its origin, and routes the MMU response back to the owning channel. It sits between the core and the MMU.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- fetch_request_enable  in  1  fetch request pulse from core
- freq_mode, freq_addr, freq_wdata, freq_wstrb  in  1/ADDR_W/DATA_W/4  fetch request payload (mode 1 = write)
- fetch_response_enable  out  1  fetch completion pulse to core
- fresp_data  out  DATA_W  fetch response data
- mem_request_enable  in  1  data request pulse from core
- mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb  in  1/ADDR_W/DATA_W/4  data request payload
- mem_response_enable  out  1  data completion pulse to core
- mresp_data  out  DATA_W  data response data
- request_enable  out  1  request pulse to MMU
- req_mode, req_addr, req_wdata, req_wstrb  out  1/ADDR_W/DATA_W/4  payload to MMU
- req_fetch  out  1  1 = instruction fetch, 0 = data access (MMU fault type)
- response_enable  in  1  MMU completion pulse
- resp_data  in  DATA_W  MMU response data
- protocol_error  out  1  sticky, set on any handshake violation

## Operation
- Each channel has one slot holding valid, mode, addr, wdata and wstrb. A request pulse loads the slot.
- FSM states: IDLE, BUSY_FETCH, BUSY_MEM.
- Leaving IDLE or completing a transaction, the FSM selects the next slot: mem slot if valid, else fetch slot. The FSM enters BUSY_MEM or BUSY_FETCH accordingly. It registers the payload and req_fetch, pulses request_enable for exactly one cycle, and clears the slot.
- In BUSY_x, response_enable pulses x_response_enable for one cycle with resp_data registered into x's data output. Data is held until the next response on that channel.
- Back-to-back: if the other slot (or the same slot, reloaded) is valid in the response cycle, the FSM goes directly to the next BUSY state. No IDLE cycle is inserted.
- Simultaneous fetch and mem pulses in IDLE: mem is issued first and fetch waits in its slot.
- A request pulse in the same cycle as a response on the other channel is buffered and issued as the next transaction.
- Violations set protocol_error (cleared only by rst):
  - Request pulse on a channel whose slot is valid or whose transaction is in flight: the pulse is dropped.
  - response_enable in IDLE: ignored.
- Outputs hold the last issued payload between requests.

## Timing
- Reset values: all outputs 0, state IDLE, both slots invalid, protocol_error 0.
- Request latency is 1 cycle. Core pulse at cycle t with IDLE and no competitor gives request_enable at t+1.
- Response latency is 1 cycle. response_enable at t gives x_response_enable and data at t+1.
- Back-to-back: response at t, next request_enable at t+1.
- Reset mid-transaction: the in-flight transaction and both slots are abandoned and no response is delivered. rst is applied to the MMU together with the arbiter. A stray response after reset hits IDLE and sets protocol_error.
- A fetch waiting behind a mem transaction is issued at most 1 cycle after that mem response.

## Structure
- Shared package `bus_arb_pkg`:
  - state enum {IDLE, BUSY_FETCH, BUSY_MEM}
  - CH_FETCH / CH_MEM constants
  - request payload struct (mode, addr, wdata, wstrb)
- Sub-module `arb_req_slot`: a one-entry buffer with load, clear, valid and overflow-detect. It is instantiated once per channel.
- Top level contains the FSM, the output registers and the response routing.

## Test plan
- Single fetch: fetch pulse, addr 0x0000_1000 at t=5 -> request_enable at t=6 with req_fetch=1 and req_addr 0x1000. response_enable at t=9 with 0xDEADBEEF -> fetch_response_enable at t=10, fresp_data 0xDEADBEEF, mem_response_enable stays 0.
- Simultaneous: fetch 0x2000 and mem write 0x8000 (wstrb 0xF, wdata 0x12345678) at the same cycle -> mem issued first (req_fetch=0, req_mode=1). Its response is followed next cycle by the fetch request 0x2000.
- Back-to-back: a mem request arrives while a fetch is in flight -> on the fetch response cycle t, request_enable for mem is at t+1 with no idle gap, and each channel receives exactly one response pulse.
- Violation: second fetch pulse while the first is in flight -> pulse dropped and protocol_error=1 permanently. response_enable in IDLE -> no core response and protocol_error=1.
- Reset mid-op: assert rst while in BUSY_MEM with the fetch slot valid -> next cycle all outputs 0 and no later request_enable. After release, a new fetch is served normally.
- Stress: 1000 random request pulses on both channels, each issued only after the previous response on that channel, with random MMU latency 1–20 cycles -> every request answered once, in order, with correct data, and protocol_error stays 0.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the core bus arbiter.
// Bus widths are fixed here so the payload struct and the interface agree.
package bus_arb_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned StrbW = 4;

    // Value driven on req_fetch for each channel.
    localparam logic ChFetch = 1'b1;
    localparam logic ChMem   = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StBusyFetch,
        StBusyMem
    } state_e;

    typedef struct packed {
        logic             mode;
        logic [AddrW-1:0] addr;
        logic [DataW-1:0] wdata;
        logic [StrbW-1:0] wstrb;
    } req_t;

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Core-side request/response channels plus the MMU request port of the arbiter.
// The master modport is the arbiter's view; slave is the core/MMU environment.
interface core_bus_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrW,
    parameter int unsigned DATA_W = DataW
);
    logic              fetch_request_enable;
    logic              freq_mode;
    logic [ADDR_W-1:0] freq_addr;
    logic [DATA_W-1:0] freq_wdata;
    logic [StrbW-1:0]  freq_wstrb;
    logic              fetch_response_enable;
    logic [DATA_W-1:0] fresp_data;

    logic              mem_request_enable;
    logic              mreq_mode;
    logic [ADDR_W-1:0] mreq_addr;
    logic [DATA_W-1:0] mreq_wdata;
    logic [StrbW-1:0]  mreq_wstrb;
    logic              mem_response_enable;
    logic [DATA_W-1:0] mresp_data;

    logic              request_enable;
    logic              req_mode;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [StrbW-1:0]  req_wstrb;
    logic              req_fetch;
    logic              response_enable;
    logic [DATA_W-1:0] resp_data;
    logic              protocol_error;

    modport master (
        input  fetch_request_enable, freq_mode, freq_addr, freq_wdata, freq_wstrb,
        input  mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb,
        input  response_enable, resp_data,
        output fetch_response_enable, fresp_data, mem_response_enable, mresp_data,
        output request_enable, req_mode, req_addr, req_wdata, req_wstrb, req_fetch,
        output protocol_error
    );

    modport slave (
        output fetch_request_enable, freq_mode, freq_addr, freq_wdata, freq_wstrb,
        output mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb,
        output response_enable, resp_data,
        input  fetch_response_enable, fresp_data, mem_response_enable, mresp_data,
        input  request_enable, req_mode, req_addr, req_wdata, req_wstrb, req_fetch,
        input  protocol_error
    );

endinterface

// File: rtl/arb_req_slot.sv
// One-entry request buffer. avail_o/data_o bypass an incoming load so the FSM
// can issue a request in the same cycle it arrives.
module arb_req_slot
    import bus_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic busy_i,
    input  logic clear_i,
    input  req_t data_i,
    output logic avail_o,
    output req_t data_o,
    output logic overflow_o
);

    logic valid_q, valid_d;
    req_t data_q, data_d;
    logic load_ok;

    always_comb begin
        overflow_o = load_i & (valid_q | busy_i);
        load_ok    = load_i & ~valid_q & ~busy_i;
        avail_o    = valid_q | load_ok;
        data_o     = valid_q ? data_q : data_i;
        valid_d    = avail_o & ~clear_i;
        data_d     = load_ok ? data_i : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Serialises fetch and data requests onto the MMU port with data-over-fetch
// priority and routes each MMU response back to the channel that owns it.
module core_bus_arbiter
    import bus_arb_pkg::*;
(
    input logic                clk,
    input logic                rst,
    core_bus_arbiter_if.master bus
);

    state_e           state_q, state_d;
    req_t             req_q, req_d;
    logic             req_fetch_q, req_fetch_d;
    logic             request_enable_q, request_enable_d;
    logic             fresp_en_q, fresp_en_d;
    logic             mresp_en_q, mresp_en_d;
    logic [DataW-1:0] fresp_data_q, fresp_data_d;
    logic [DataW-1:0] mresp_data_q, mresp_data_d;
    logic             perr_q, perr_d;

    req_t f_in, m_in, f_data, m_data;
    logic f_avail, m_avail, f_ovf, m_ovf, f_clear, m_clear, issue;

    assign f_in = '{mode: bus.freq_mode, addr: bus.freq_addr, wdata: bus.freq_wdata,
                    wstrb: bus.freq_wstrb};
    assign m_in = '{mode: bus.mreq_mode, addr: bus.mreq_addr, wdata: bus.mreq_wdata,
                    wstrb: bus.mreq_wstrb};

    arb_req_slot u_fetch_slot (
        .clk        (clk),
        .rst        (rst),
        .load_i     (bus.fetch_request_enable),
        .busy_i     (state_q == StBusyFetch),
        .clear_i    (f_clear),
        .data_i     (f_in),
        .avail_o    (f_avail),
        .data_o     (f_data),
        .overflow_o (f_ovf)
    );

    arb_req_slot u_mem_slot (
        .clk        (clk),
        .rst        (rst),
        .load_i     (bus.mem_request_enable),
        .busy_i     (state_q == StBusyMem),
        .clear_i    (m_clear),
        .data_i     (m_in),
        .avail_o    (m_avail),
        .data_o     (m_data),
        .overflow_o (m_ovf)
    );

    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        req_fetch_d      = req_fetch_q;
        request_enable_d = 1'b0;
        fresp_en_d       = 1'b0;
        mresp_en_d       = 1'b0;
        fresp_data_d     = fresp_data_q;
        mresp_data_d     = mresp_data_q;
        perr_d           = perr_q | f_ovf | m_ovf;
        f_clear          = 1'b0;
        m_clear          = 1'b0;
        issue            = 1'b0;

        unique case (state_q)
            StIdle: begin
                issue = 1'b1;
                if (bus.response_enable) perr_d = 1'b1;
            end
            StBusyFetch: begin
                if (bus.response_enable) begin
                    fresp_en_d   = 1'b1;
                    fresp_data_d = bus.resp_data;
                    issue        = 1'b1;
                end
            end
            StBusyMem: begin
                if (bus.response_enable) begin
                    mresp_en_d   = 1'b1;
                    mresp_data_d = bus.resp_data;
                    issue        = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pick the next slot without an idle cycle; mem wins over fetch.
        if (issue) begin
            state_d = StIdle;
            if (m_avail) begin
                state_d          = StBusyMem;
                req_d            = m_data;
                req_fetch_d      = ChMem;
                request_enable_d = 1'b1;
                m_clear          = 1'b1;
            end else if (f_avail) begin
                state_d          = StBusyFetch;
                req_d            = f_data;
                req_fetch_d      = ChFetch;
                request_enable_d = 1'b1;
                f_clear          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            req_q            <= '0;
            req_fetch_q      <= 1'b0;
            request_enable_q <= 1'b0;
            fresp_en_q       <= 1'b0;
            mresp_en_q       <= 1'b0;
            fresp_data_q     <= '0;
            mresp_data_q     <= '0;
            perr_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            req_fetch_q      <= req_fetch_d;
            request_enable_q <= request_enable_d;
            fresp_en_q       <= fresp_en_d;
            mresp_en_q       <= mresp_en_d;
            fresp_data_q     <= fresp_data_d;
            mresp_data_q     <= mresp_data_d;
            perr_q           <= perr_d;
        end
    end

    assign bus.request_enable        = request_enable_q;
    assign bus.req_mode              = req_q.mode;
    assign bus.req_addr              = req_q.addr;
    assign bus.req_wdata             = req_q.wdata;
    assign bus.req_wstrb             = req_q.wstrb;
    assign bus.req_fetch             = req_fetch_q;
    assign bus.fetch_response_enable = fresp_en_q;
    assign bus.fresp_data            = fresp_data_q;
    assign bus.mem_response_enable   = mresp_en_q;
    assign bus.mresp_data            = mresp_data_q;
    assign bus.protocol_error        = perr_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed and randomised-latency checks for core_bus_arbiter.
module tb_core_bus_arbiter;
    import bus_arb_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    core_bus_arbiter_if bus ();

    core_bus_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        bus.fetch_request_enable = 1'b0;
        bus.mem_request_enable   = 1'b0;
        bus.response_enable      = 1'b0;
    endtask

    task automatic drive_fetch(input logic [31:0] addr);
        bus.fetch_request_enable = 1'b1;
        bus.freq_mode            = 1'b0;
        bus.freq_addr            = addr;
        bus.freq_wdata           = '0;
        bus.freq_wstrb           = '0;
    endtask

    task automatic drive_mem(input logic mode, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        bus.mem_request_enable = 1'b1;
        bus.mreq_mode          = mode;
        bus.mreq_addr          = addr;
        bus.mreq_wdata         = wdata;
        bus.mreq_wstrb         = wstrb;
    endtask

    task automatic drive_resp(input logic [31:0] data);
        bus.response_enable = 1'b1;
        bus.resp_data       = data;
    endtask

    function automatic logic [31:0] mmu_data(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0F0F;
    endfunction

    // Stress-phase state
    logic        f_out, m_out, f_pend, m_pend, mmu_busy;
    logic [31:0] f_addr, m_addr, m_wdata, mmu_addr;
    int          mmu_cnt, sent, f_sent, m_sent, f_done, m_done, cyc;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.fetch_request_enable = 1'b0;
        bus.freq_mode  = 1'b0;
        bus.freq_addr  = '0;
        bus.freq_wdata = '0;
        bus.freq_wstrb = '0;
        bus.mem_request_enable = 1'b0;
        bus.mreq_mode  = 1'b0;
        bus.mreq_addr  = '0;
        bus.mreq_wdata = '0;
        bus.mreq_wstrb = '0;
        bus.response_enable = 1'b0;
        bus.resp_data  = '0;

        step();
        step();
        check("rst_req_en", bus.request_enable, 0);
        check("rst_req_addr", bus.req_addr, 0);
        check("rst_req_fetch", bus.req_fetch, 0);
        check("rst_fresp_en", bus.fetch_response_enable, 0);
        check("rst_mresp_data", bus.mresp_data, 0);
        check("rst_perr", bus.protocol_error, 0);
        rst = 1'b0;
        step();
        check("idle_req_en", bus.request_enable, 0);

        // Single fetch
        drive_fetch(32'h0000_1000);
        step();
        check("f1_req_en", bus.request_enable, 1);
        check("f1_req_fetch", bus.req_fetch, 1);
        check("f1_req_addr", bus.req_addr, 32'h1000);
        check("f1_req_mode", bus.req_mode, 0);
        step();
        check("f1_req_pulse", bus.request_enable, 0);
        check("f1_addr_hold", bus.req_addr, 32'h1000);
        step();
        drive_resp(32'hDEAD_BEEF);
        step();
        check("f1_fresp_en", bus.fetch_response_enable, 1);
        check("f1_fresp_data", bus.fresp_data, 32'hDEAD_BEEF);
        check("f1_mresp_en", bus.mem_response_enable, 0);
        step();
        check("f1_fresp_pulse", bus.fetch_response_enable, 0);
        check("f1_fresp_hold", bus.fresp_data, 32'hDEAD_BEEF);

        // Simultaneous: mem first, fetch right after mem response
        drive_fetch(32'h0000_2000);
        drive_mem(1'b1, 32'h0000_8000, 32'h1234_5678, 4'hF);
        step();
        check("sim_req_en", bus.request_enable, 1);
        check("sim_req_fetch", bus.req_fetch, 0);
        check("sim_req_mode", bus.req_mode, 1);
        check("sim_req_addr", bus.req_addr, 32'h8000);
        check("sim_req_wdata", bus.req_wdata, 32'h1234_5678);
        check("sim_req_wstrb", bus.req_wstrb, 4'hF);
        step();
        check("sim_wait", bus.request_enable, 0);
        drive_resp(32'hAAAA_5555);
        step();
        check("sim_mresp_en", bus.mem_response_enable, 1);
        check("sim_mresp_data", bus.mresp_data, 32'hAAAA_5555);
        check("sim_f_req_en", bus.request_enable, 1);
        check("sim_f_req_fetch", bus.req_fetch, 1);
        check("sim_f_req_addr", bus.req_addr, 32'h2000);
        drive_resp(32'h1111_2222);
        step();
        check("sim_fresp_en", bus.fetch_response_enable, 1);
        check("sim_fresp_data", bus.fresp_data, 32'h1111_2222);
        check("sim_mresp_off", bus.mem_response_enable, 0);
        check("sim_mresp_hold", bus.mresp_data, 32'hAAAA_5555);

        // Back-to-back: mem arrives while fetch in flight
        drive_fetch(32'h0000_3000);
        step();
        check("b2b_f_req", bus.request_enable, 1);
        drive_mem(1'b0, 32'h0000_9000, 32'h0, 4'h0);
        step();
        check("b2b_m_buffered", bus.request_enable, 0);
        drive_resp(32'h0000_0033);
        step();
        check("b2b_fresp_en", bus.fetch_response_enable, 1);
        check("b2b_mresp_en0", bus.mem_response_enable, 0);
        check("b2b_m_req_en", bus.request_enable, 1);
        check("b2b_m_req_fetch", bus.req_fetch, 0);
        check("b2b_m_req_addr", bus.req_addr, 32'h9000);
        drive_resp(32'h0000_0044);
        step();
        check("b2b_mresp_en", bus.mem_response_enable, 1);
        check("b2b_mresp_data", bus.mresp_data, 32'h44);
        check("b2b_fresp_en0", bus.fetch_response_enable, 0);
        check("b2b_no_req", bus.request_enable, 0);
        step();
        check("b2b_quiet_f", bus.fetch_response_enable, 0);
        check("b2b_quiet_m", bus.mem_response_enable, 0);
        check("b2b_perr", bus.protocol_error, 0);

        // Violation: second fetch while first in flight, then response in idle
        drive_fetch(32'h0000_4000);
        step();
        check("viol_req", bus.request_enable, 1);
        drive_fetch(32'h0000_5000);
        step();
        check("viol_perr", bus.protocol_error, 1);
        drive_resp(32'h0000_0055);
        step();
        check("viol_fresp", bus.fetch_response_enable, 1);
        check("viol_dropped", bus.request_enable, 0);
        step();
        check("viol_dropped2", bus.request_enable, 0);
        drive_resp(32'h0000_0066);
        step();
        check("idle_resp_f", bus.fetch_response_enable, 0);
        check("idle_resp_m", bus.mem_response_enable, 0);
        check("idle_resp_data", bus.fresp_data, 32'h55);
        step();
        check("perr_sticky", bus.protocol_error, 1);

        // Reset mid-transaction
        rst = 1'b1;
        step();
        check("rst2_perr", bus.protocol_error, 0);
        rst = 1'b0;
        step();
        drive_mem(1'b0, 32'h0000_A000, 32'h0, 4'h0);
        drive_fetch(32'h0000_B000);
        step();
        check("mid_req", bus.request_enable, 1);
        check("mid_req_addr", bus.req_addr, 32'hA000);
        rst = 1'b1;
        step();
        check("mid_rst_req_en", bus.request_enable, 0);
        check("mid_rst_addr", bus.req_addr, 0);
        check("mid_rst_fresp", bus.fresp_data, 0);
        check("mid_rst_mresp", bus.mresp_data, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_req", bus.request_enable, 0);
        end
        drive_resp(32'h0000_0077);
        step();
        check("stray_perr", bus.protocol_error, 1);
        check("stray_no_resp", bus.mem_response_enable, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        drive_fetch(32'h0000_C000);
        step();
        check("post_req", bus.request_enable, 1);
        check("post_req_addr", bus.req_addr, 32'hC000);
        check("post_req_fetch", bus.req_fetch, 1);
        drive_resp(32'hCAFE_F00D);
        step();
        check("post_fresp", bus.fresp_data, 32'hCAFE_F00D);
        check("post_perr", bus.protocol_error, 0);

        // Stress: random requests, random MMU latency 1..20
        f_out = 0; m_out = 0; f_pend = 0; m_pend = 0; mmu_busy = 0;
        f_addr = 0; m_addr = 0; m_wdata = 0; mmu_addr = 0; mmu_cnt = 0;
        sent = 0; f_sent = 0; m_sent = 0; f_done = 0; m_done = 0; cyc = 0;
        while (!(sent == 1000 && !f_out && !m_out) && cyc < 60000) begin
            if (!f_out && sent < 1000 && $urandom_range(0, 2) == 0) begin
                f_addr = $urandom;
                drive_fetch(f_addr);
                f_out = 1; f_pend = 1; sent++; f_sent++;
            end
            if (!m_out && sent < 1000 && $urandom_range(0, 2) == 0) begin
                m_addr  = $urandom;
                m_wdata = $urandom;
                drive_mem(1'(sent % 2), m_addr, m_wdata, 4'(sent));
                m_out = 1; m_pend = 1; sent++; m_sent++;
            end
            if (mmu_busy) begin
                if (mmu_cnt == 0) begin
                    drive_resp(mmu_data(mmu_addr));
                    mmu_busy = 0;
                end else begin
                    mmu_cnt--;
                end
            end
            step();
            cyc++;
            if (bus.fetch_response_enable) begin
                check("st_f_outstanding", f_out, 1);
                check("st_f_issued", f_pend, 0);
                check("st_fresp_data", bus.fresp_data, mmu_data(f_addr));
                f_out = 0;
                f_done++;
            end
            if (bus.mem_response_enable) begin
                check("st_m_outstanding", m_out, 1);
                check("st_m_issued", m_pend, 0);
                check("st_mresp_data", bus.mresp_data, mmu_data(m_addr));
                m_out = 0;
                m_done++;
            end
            if (bus.request_enable) begin
                check("st_mmu_idle", mmu_busy, 0);
                if (bus.req_fetch) begin
                    check("st_f_pend", f_pend, 1);
                    check("st_f_addr", bus.req_addr, f_addr);
                    f_pend = 0;
                end else begin
                    check("st_m_pend", m_pend, 1);
                    check("st_m_addr", bus.req_addr, m_addr);
                    check("st_m_wdata", bus.req_wdata, m_wdata);
                    m_pend = 0;
                end
                mmu_busy = 1;
                mmu_addr = bus.req_addr;
                mmu_cnt  = $urandom_range(1, 20);
            end
        end
        check("st_total", sent, 1000);
        check("st_f_count", f_done, f_sent);
        check("st_m_count", m_done, m_sent);
        check("st_perr", bus.protocol_error, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
